dual_dice_roller: RTL and testbench



---
 rtl/dual_dice_roller.sv | 143 ++++++++++++++
 tb/tb_dual_dice_roller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_dice_roller.sv
// dual_dice_roller
//   Produces four die faces (a,b = player 1, c,d = player 2) for the
//   dual-dice sum/compare stage. A free-running 16-bit LFSR supplies
//   entropy; each accepted rising edge of roll_req tumbles all dice for
//   SPIN_CYCLES updates, then freezes them and pulses valid for one cycle.
//   Dice are always in 1..6.
//
//   Parameters:
//     SPIN_CYCLES  tumble updates per roll, legal range 1..255 (default 16)
//     SEED         LFSR reset value; 0 is replaced by 16'h0001
//
//   Ports:
//     clk          sole clock, rising edge
//     rst_n        asynchronous active-low reset
//     roll_req     roll strobe, acted on at its rising edge only
//     hold[3:0]    per-die freeze (bit0=a .. bit3=d), only with DICE_HOLD_EN
//     a,b,c,d      registered die values 1..6
//     busy         high while tumbling
//     valid        one-cycle pulse when a new set of dice is final
//     roll_count   completed rolls, wraps 255 -> 0
//
//   Build option: define DICE_HOLD_EN to add the hold port.
module dual_dice_roller #(
    parameter int unsigned SPIN_CYCLES = 16,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll_req,
`ifdef DICE_HOLD_EN
    input  logic [3:0] hold,
`endif
    output logic [2:0] a,
    output logic [2:0] b,
    output logic [2:0] c,
    output logic [2:0] d,
    output logic       busy,
    output logic       valid,
    output logic [7:0] roll_count
);

    // Encoding chosen so busy and valid are single state bits.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SPIN = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  CNT_LAST  = 8'(SPIN_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lfsr;
    logic        roll_prev;
    logic [7:0]  cnt;
    logic [2:0]  dice [4];
    logic [3:0]  hold_mask;
    logic        rise;
    logic        last;

`ifdef DICE_HOLD_EN
    assign hold_mask = hold;
`else
    assign hold_mask = 4'b0000;
`endif

    assign rise = roll_req & ~roll_prev;
    assign last = (cnt == CNT_LAST);

    // Advance a die by r+1 faces (r = 0..3) with wrap 6 -> 1.
    // die + r equals (die-1) + step, which is at most 9, so one
    // conditional subtract is a complete mod 6.
    function automatic logic [2:0] next_die(input logic [2:0] die,
                                            input logic [1:0] r);
        logic [3:0] v;
        v = {1'b0, die} + {2'b00, r};
        if (v >= 4'd6)
            v = v - 4'd6;
        return v[2:0] + 3'd1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; rises outside IDLE are simply ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = SPIN;
            SPIN:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        busy  = (state == SPIN);
        valid = (state == DONE);
    end

    // Entropy, edge detect, tumble counter, dice and roll counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= LFSR_INIT;
            roll_prev  <= 1'b0;
            cnt        <= 8'd0;
            roll_count <= 8'd0;
            for (int k = 0; k < 4; k++)
                dice[k] <= 3'd1;
        end else begin
            lfsr      <= lfsr_step(lfsr);
            roll_prev <= roll_req;
            if (state == IDLE && rise)
                cnt <= 8'd0;
            else if (state == SPIN)
                cnt <= cnt + 8'd1;
            if (state == SPIN && last)
                roll_count <= roll_count + 8'd1;
            if (state == SPIN) begin
                for (int k = 0; k < 4; k++)
                    if (!hold_mask[k])
                        dice[k] <= next_die(dice[k], lfsr[2*k +: 2]);
            end
        end
    end

    assign a = dice[0];
    assign b = dice[1];
    assign c = dice[2];
    assign d = dice[3];

endmodule

// File: tb/tb_dual_dice_roller.sv
module tb_dual_dice_roller;

    localparam int          SPIN_M = 16;
    localparam logic [15:0] SEED_M = 16'h5A3C;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic roll_a = 1'b0;
    logic roll_z = 1'b0;
    logic roll_m = 1'b0;
`ifdef DICE_HOLD_EN
    logic [3:0] hold_a = 4'b0001;
`endif

    logic [2:0] a_a, b_a, c_a, d_a, a_z, b_z, c_z, d_z, a_m, b_m, c_m, d_m;
    logic       busy_a, valid_a, busy_z, valid_z, busy_m, valid_m;
    logic [7:0] cnt_a, cnt_z, cnt_m;

    typedef struct {
        logic [2:0] a, b, c, d;
        logic [7:0] cnt;
    } exp_t;

    exp_t qa[$], qz[$], qm[$];
    exp_t ea, ez, em;

    int vectors     = 0;
    int miscompares = 0;
    int pulses_m    = 0;

    always #5 clk = ~clk;

    dual_dice_roller #(.SPIN_CYCLES(1), .SEED(16'h0001)) u_a (
        .clk(clk), .rst_n(rst_n), .roll_req(roll_a),
`ifdef DICE_HOLD_EN
        .hold(hold_a),
`endif
        .a(a_a), .b(b_a), .c(c_a), .d(d_a),
        .busy(busy_a), .valid(valid_a), .roll_count(cnt_a));

    dual_dice_roller #(.SPIN_CYCLES(1), .SEED(16'h0000)) u_z (
        .clk(clk), .rst_n(rst_n), .roll_req(roll_z),
`ifdef DICE_HOLD_EN
        .hold(4'b0000),
`endif
        .a(a_z), .b(b_z), .c(c_z), .d(d_z),
        .busy(busy_z), .valid(valid_z), .roll_count(cnt_z));

    dual_dice_roller #(.SPIN_CYCLES(SPIN_M), .SEED(SEED_M)) u_m (
        .clk(clk), .rst_n(rst_n), .roll_req(roll_m),
`ifdef DICE_HOLD_EN
        .hold(4'b0000),
`endif
        .a(a_m), .b(b_m), .c(c_m), .d(d_m),
        .busy(busy_m), .valid(valid_m), .roll_count(cnt_m));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [2:0] a, b, c, d,
                       input logic [7:0] n);
        check({tag, "_a"}, a, e.a);
        check({tag, "_b"}, b, e.b);
        check({tag, "_c"}, c, e.c);
        check({tag, "_d"}, d, e.d);
        check({tag, "_cnt"}, n, e.cnt);
    endtask

    // Reference LFSR for u_m, tracks the pre-edge value at every negedge
    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    logic [15:0] mlfsr;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) mlfsr <= SEED_M;
        else        mlfsr <= lstep(mlfsr);

    int md[4] = '{1, 1, 1, 1};

    // Called just before the edge that samples the rise: that edge steps
    // the LFSR once, then each of the SPIN_M following edges updates dice.
    task automatic predict_m(input logic [7:0] n);
        logic [15:0] l;
        exp_t        e;
        l = lstep(mlfsr);
        for (int s = 0; s < SPIN_M; s++) begin
            for (int k = 0; k < 4; k++)
                md[k] = (md[k] - 1 + int'(l[2*k +: 2]) + 1) % 6 + 1;
            l = lstep(l);
        end
        e.a = 3'(md[0]); e.b = 3'(md[1]); e.c = 3'(md[2]); e.d = 3'(md[3]);
        e.cnt = n;
        qm.push_back(e);
    endtask

    task automatic push_const(input int which, input int a, b, c, d, n);
        exp_t e;
        e.a = 3'(a); e.b = 3'(b); e.c = 3'(c); e.d = 3'(d); e.cnt = 8'(n);
        if (which == 0) qa.push_back(e);
        else            qz.push_back(e);
    endtask

    // Scoreboard pop on every valid, plus per-cycle die range checks
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_a) begin
                check("a_expected_pending", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    cmp("a_roll", ea, a_a, b_a, c_a, d_a, cnt_a);
                end
            end
            if (valid_z) begin
                check("z_expected_pending", qz.size() > 0, 1);
                if (qz.size() > 0) begin
                    ez = qz.pop_front();
                    cmp("z_roll", ez, a_z, b_z, c_z, d_z, cnt_z);
                end
            end
            if (valid_m) begin
                pulses_m++;
                check("m_expected_pending", qm.size() > 0, 1);
                if (qm.size() > 0) begin
                    em = qm.pop_front();
                    cmp("m_roll", em, a_m, b_m, c_m, d_m, cnt_m);
                end
            end
            check("m_range_a", (a_m >= 3'd1 && a_m <= 3'd6), 1);
            check("m_range_b", (b_m >= 3'd1 && b_m <= 3'd6), 1);
            check("m_range_c", (c_m >= 3'd1 && c_m <= 3'd6), 1);
            check("m_range_d", (d_m >= 3'd1 && d_m <= 3'd6), 1);
        end
    end

    task automatic check_reset(input string tag, input logic [2:0] a, b, c, d,
                               input logic bz, input logic v, input logic [7:0] n);
        check({tag, "_a"}, a, 1);
        check({tag, "_b"}, b, 1);
        check({tag, "_c"}, c, 1);
        check({tag, "_d"}, d, 1);
        check({tag, "_busy"}, bz, 0);
        check({tag, "_valid"}, v, 0);
        check({tag, "_cnt"}, n, 0);
    endtask

    initial begin
        // Asynchronous reset applied mid-cycle
        #3 rst_n = 1'b0;
        #1 check_reset("rst_m", a_m, b_m, c_m, d_m, busy_m, valid_m, cnt_m);
        check_reset("rst_a", a_a, b_a, c_a, d_a, busy_a, valid_a, cnt_a);

        // Single roll, SEED 1 and SEED 0, SPIN_CYCLES 1
        @(negedge clk);
        rst_n  = 1'b1;
        roll_a = 1'b1;
        roll_z = 1'b1;
`ifdef DICE_HOLD_EN
        push_const(0, 1, 2, 2, 2, 1);
`else
        push_const(0, 4, 2, 2, 2, 1);
`endif
        push_const(1, 4, 2, 2, 2, 1);
        @(posedge clk); #1;
        check("single_busy_e1", busy_a, 1);
        check("single_valid_e1", valid_a, 0);
        @(posedge clk); #1;
        check("single_valid_e2", valid_a, 1);
        check("single_busy_e2", busy_a, 0);
        check("single_cnt_e2", cnt_a, 1);
        check("seed0_valid_e2", valid_z, 1);
        @(posedge clk); #1;
        check("single_valid_e3", valid_a, 0);
        check("seed0_valid_e3", valid_z, 0);
        @(negedge clk);
        roll_a = 1'b0;
        roll_z = 1'b0;

        // Button held for 40 cycles: one roll only
        @(negedge clk);
        roll_m = 1'b1;
        predict_m(8'd1);
        repeat (40) @(negedge clk);
        roll_m = 1'b0;
        repeat (3) @(negedge clk);
        check("held_pulses", pulses_m, 1);
        check("held_count", cnt_m, 1);

        // Second rise during SPIN is dropped
        roll_m = 1'b1;
        predict_m(8'd2);
        @(negedge clk);
        roll_m = 1'b0;
        repeat (3) @(negedge clk);
        roll_m = 1'b1;
        @(negedge clk);
        roll_m = 1'b0;
        repeat (25) @(negedge clk);
        check("drop_pulses", pulses_m, 2);
        check("drop_count", cnt_m, 2);

        // Reset 5 cycles into SPIN, then a fresh roll
        roll_m = 1'b1;
        @(negedge clk);
        roll_m = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        md = '{1, 1, 1, 1};
        #1 check_reset("midrst_m", a_m, b_m, c_m, d_m, busy_m, valid_m, cnt_m);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst_no_valid", pulses_m, 2);
        roll_m = 1'b1;
        predict_m(8'd1);
        @(negedge clk);
        roll_m = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_fresh_count", cnt_m, 1);
        check("midrst_fresh_pulses", pulses_m, 3);

        // 300 back-to-back rolls at maximum throughput
        rst_n = 1'b0;
        md = '{1, 1, 1, 1};
        @(negedge clk);
        rst_n    = 1'b1;
        pulses_m = 0;
        for (int i = 0; i < 300; i++) begin
            roll_m = 1'b1;
            predict_m(8'(i + 1));
            @(negedge clk);
            roll_m = 1'b0;
            repeat (SPIN_M + 1) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("wrap_count", cnt_m, 44);
        check("wrap_pulses", pulses_m, 300);

        check("qa_drained", qa.size(), 0);
        check("qz_drained", qz.size(), 0);
        check("qm_drained", qm.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
